// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions: default frame geometry, sample type and index bit reversal.
// Consumed by the SIPO frame buffer and its bank storage.
package fft_pkg;

  localparam int N_PTS_DEF = 16;
  localparam int DW_DEF    = 16;
  localparam int LOG2N     = $clog2(N_PTS_DEF);

  typedef logic [DW_DEF-1:0] sample_t;

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits = LOG2N);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) r[i] = idx[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// One frame of N_PTS x DW sample registers: single write port, whole frame always visible on rd_bus.
// Write lands on the next rising edge; no backpressure, rst clears the contents asynchronously.
module fft_frame_bank #(
  parameter int N_PTS = 16,
  parameter int DW    = 16,
  localparam int AW   = $clog2(N_PTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [DW-1:0]       wdata,
  output logic [N_PTS*DW-1:0] rd_bus
);

  logic [N_PTS*DW-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[int'(waddr)*DW +: DW] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '0;
    else     mem_q <= mem_d;
  end

  assign rd_bus = mem_q;

endmodule

// File: rtl/fft_sipo_frame_buf.sv
// Ping-pong serial-in/parallel-out frame buffer; frame valid the cycle after its last accept, s_ready low while
// the write bank is full or flush is high. Define FFT_SIPO_BITREV_EN to store frames in bit-reversed slot order.
module fft_sipo_frame_buf
  import fft_pkg::*;
#(
  parameter int N_PTS = N_PTS_DEF,
  parameter int DW    = DW_DEF,
  localparam int AW   = $clog2(N_PTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic [DW-1:0]       s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [N_PTS*DW-1:0] m_frame,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [7:0]          ovf_cnt
);

  logic [AW-1:0]       wr_idx_q, wr_idx_d;
  logic                wr_bank_q, wr_bank_d;
  logic                rd_bank_q, rd_bank_d;
  logic [1:0]          full_q, full_d;
  logic [7:0]          ovf_cnt_q, ovf_cnt_d;
  logic                accept, last, hs;
  logic [1:0]          bank_we;
  logic [AW-1:0]       waddr;
  logic [N_PTS*DW-1:0] bus0, bus1;

  assign s_ready = !full_q[wr_bank_q] && !flush;
  assign accept  = s_valid && s_ready;
  assign last    = accept && (wr_idx_q == AW'(N_PTS-1));
  assign m_valid = full_q[rd_bank_q];
  assign hs      = m_valid && m_ready;
  assign bank_we = {accept && wr_bank_q, accept && !wr_bank_q};
  assign m_frame = rd_bank_q ? bus1 : bus0;
  assign ovf_cnt = ovf_cnt_q;

`ifdef FFT_SIPO_BITREV_EN
  assign waddr = AW'(bitrev(32'(wr_idx_q), AW));
`else
  assign waddr = wr_idx_q;
`endif

  // Completion and handshake always target different banks, so both updates may apply in one edge.
  always_comb begin
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    ovf_cnt_d = ovf_cnt_q;
    if (flush)       wr_idx_d = '0;
    else if (accept) wr_idx_d = wr_idx_q + 1'b1;
    if (last) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = !wr_bank_q;
    end
    if (hs) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (s_valid && !s_ready && ovf_cnt_q != 8'hff) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      ovf_cnt_q <= 8'd0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  fft_frame_bank #(.N_PTS(N_PTS), .DW(DW)) u_bank0 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we[0]),
    .waddr (waddr),
    .wdata (s_data),
    .rd_bus(bus0)
  );

  fft_frame_bank #(.N_PTS(N_PTS), .DW(DW)) u_bank1 (
    .clk   (clk),
    .rst   (rst),
    .we    (bank_we[1]),
    .waddr (waddr),
    .wdata (s_data),
    .rd_bus(bus1)
  );

endmodule

// File: tb/tb_fft_sipo_frame_buf.sv
// Self-checking bench for fft_sipo_frame_buf: vector table for streaming, directed sequences for stalls,
// flush, reset and simultaneous completion/handshake; frames are checked against a scoreboard queue.
module tb_fft_sipo_frame_buf;

  localparam int N  = 16;
  localparam int DW = 16;
  localparam int FW = N * DW;

`ifdef FFT_SIPO_BITREV_EN
  localparam logic [15:0] SLOT1_EXP = 16'd9;
  localparam logic [15:0] SLOT8_EXP = 16'd2;
`else
  localparam logic [15:0] SLOT1_EXP = 16'd2;
  localparam logic [15:0] SLOT8_EXP = 16'd9;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [FW-1:0] m_frame;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    ovf_cnt;

  int total = 0;
  int bad   = 0;

  logic [FW-1:0] sb[$];

  typedef struct {
    logic          vld;
    logic [DW-1:0] dat;
    logic          mrdy;
    logic          exp_srdy;
    logic          exp_mvld;
  } vec_t;

  vec_t tbl[18];

  always #5 clk = ~clk;

  fft_sipo_frame_buf #(.N_PTS(N), .DW(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .s_data (s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .m_frame(m_frame),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .ovf_cnt(ovf_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_frame(input int base);
    logic [FW-1:0] f;
    logic [3:0]    k, a;
    f = '0;
    for (int i = 0; i < N; i++) begin
      k = 4'(i);
`ifdef FFT_SIPO_BITREV_EN
      a = {k[0], k[1], k[2], k[3]};
`else
      a = k;
`endif
      f[int'(a)*DW +: DW] = 16'(base + i);
    end
    return f;
  endfunction

  // Every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: frame %h delivered, none expected", m_frame);
      end else begin
        check_frame("sb_frame", m_frame, sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    m_ready = 1'b0;
    flush   = 1'b0;
    rst     = 1'b1;
    #2;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_ovf", 32'(ovf_cnt), 32'd0);
    check_frame("rst_m_frame", m_frame, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic send_one(input logic [DW-1:0] d);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data  = d;
    #1;
    while (!s_ready && w < 200) begin
      @(posedge clk);
      #2;
      w++;
    end
    if (w >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: s_ready stuck at 0 for sample %0d", d);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_run(input int base, input int n);
    for (int i = 0; i < n; i++) send_one(16'(base + i));
  endtask

  task automatic take_frame(input int base);
    sb.push_back(mk_frame(base));
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 18; i++) begin
      tbl[i].vld      = (i < 16);
      tbl[i].dat      = (i < 16) ? 16'(i + 1) : 16'd0;
      tbl[i].mrdy     = 1'b1;
      tbl[i].exp_srdy = 1'b1;
      tbl[i].exp_mvld = (i == 16);
    end

    #0;
    do_reset();

    // Reset while a full frame is waiting and the next one is partial.
    send_run(1, 16);
    check("t1_mvld_before", 32'(m_valid), 32'd1);
    send_run(17, 7);
    do_reset();
    send_run(201, 16);
    check("t1_mvld_clean", 32'(m_valid), 32'd1);
    check_frame("t1_clean_frame", m_frame, mk_frame(201));
    take_frame(201);
    check("t1_mvld_after", 32'(m_valid), 32'd0);

    // Back-to-back streaming from the vector table.
    do_reset();
    sb.push_back(mk_frame(1));
    for (int i = 0; i < 18; i++) begin
      s_valid = tbl[i].vld;
      s_data  = tbl[i].dat;
      m_ready = tbl[i].mrdy;
      #1;
      check($sformatf("t2_srdy_%0d", i), 32'(s_ready), 32'(tbl[i].exp_srdy));
      check($sformatf("t2_mvld_%0d", i), 32'(m_valid), 32'(tbl[i].exp_mvld));
      if (i == 16) begin
        check("t2_slot1", 32'(m_frame[1*DW +: DW]), 32'(SLOT1_EXP));
        check("t2_slot8", 32'(m_frame[8*DW +: DW]), 32'(SLOT8_EXP));
      end
      @(posedge clk);
      #1;
    end
    m_ready = 1'b0;
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Both banks fill, input stalls and overflow counts, then drain.
    do_reset();
    for (int c = 0; c < 40; c++) begin
      s_valid = 1'b1;
      s_data  = (c < 32) ? 16'(c + 1) : 16'd33;
      #1;
      check($sformatf("t3_srdy_%0d", c), 32'(s_ready), (c < 32) ? 32'd1 : 32'd0);
      check($sformatf("t3_ovf_%0d", c), 32'(ovf_cnt), (c < 32) ? 32'd0 : 32'(c - 32));
      @(posedge clk);
      #1;
    end
    sb.push_back(mk_frame(1));
    sb.push_back(mk_frame(17));
    m_ready = 1'b1;
    #1;
    check("t3_hs1_srdy", 32'(s_ready), 32'd0);
    check("t3_hs1_mvld", 32'(m_valid), 32'd1);
    check("t3_hs1_ovf", 32'(ovf_cnt), 32'd8);
    tick();
    check("t3_hs2_srdy", 32'(s_ready), 32'd1);
    check("t3_hs2_mvld", 32'(m_valid), 32'd1);
    check("t3_hs2_ovf", 32'(ovf_cnt), 32'd9);
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check("t3_drained_mvld", 32'(m_valid), 32'd0);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);
    tick();

    // Flush mid-frame, held one and three cycles.
    for (int f = 1; f <= 3; f += 2) begin
      do_reset();
      send_run(1, 5);
      flush   = 1'b1;
      s_valid = 1'b1;
      s_data  = 16'hdead;
      for (int k = 0; k < f; k++) begin
        #1;
        check($sformatf("t4_flush%0d_srdy", f), 32'(s_ready), 32'd0);
        @(posedge clk);
        #1;
      end
      flush   = 1'b0;
      s_valid = 1'b0;
      send_run(101, 15);
      check($sformatf("t4_flush%0d_not_full", f), 32'(m_valid), 32'd0);
      send_one(16'd116);
      check($sformatf("t4_flush%0d_mvld", f), 32'(m_valid), 32'd1);
      take_frame(101);
      check($sformatf("t4_flush%0d_sb", f), 32'(sb.size()), 32'd0);
    end

    // Completion of bank 1 in the same edge as the handshake of bank 0.
    do_reset();
    send_run(1, 16);
    send_run(17, 15);
    sb.push_back(mk_frame(1));
    s_valid = 1'b1;
    s_data  = 16'd32;
    m_ready = 1'b1;
    #1;
    check("t5_pre_mvld", 32'(m_valid), 32'd1);
    tick();
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check("t5_post_mvld", 32'(m_valid), 32'd1);
    check_frame("t5_post_frame", m_frame, mk_frame(17));
    tick();
    take_frame(17);
    check("t5_end_mvld", 32'(m_valid), 32'd0);
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // Overflow counter saturation.
    do_reset();
    send_run(1, 32);
    s_valid = 1'b1;
    s_data  = 16'd99;
    for (int c = 0; c < 300; c++) begin
      #1;
      if (c == 100) check("t6_ovf_100", 32'(ovf_cnt), 32'd100);
      if (c == 255) check("t6_ovf_255", 32'(ovf_cnt), 32'd255);
      @(posedge clk);
      #1;
    end
    #1;
    check("t6_ovf_sat", 32'(ovf_cnt), 32'd255);
    check("t6_srdy", 32'(s_ready), 32'd0);
    tick();
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
